// File: rtl/booth_mul_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : booth_pkg
//  Purpose  : Shared types and helpers for the sequential Booth multiplier.
//             FSM state encoding, radix-4 digit encoding and the function
//             that gives the iteration count for a width/radix pair.
//  Ports    : none (package)
//  Revision : 1.0  initial parametrised release
// ============================================================================
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Booth digit selected for one iteration.
    typedef enum logic [2:0] {
        ZERO = 3'd0,
        P1   = 3'd1,
        P2   = 3'd2,
        M1   = 3'd3,
        M2   = 3'd4
    } digit_t;

    // Operands are extended by two bits; radix-4 retires two bits per step.
    function automatic int booth_iters(input int width, input bit radix4);
        return radix4 ? (width + 2) / 2 : width + 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/booth_mul_seq_if.sv
`default_nettype none
// ============================================================================
//  Module   : booth_mul_seq_if
//  Purpose  : Request/response bundle between the ALU control FSM (master)
//             and the multi-cycle Booth multiplier (slave).
//  Signals  : start, sign_mode, x, y  (master -> slave)
//             busy, done, z           (slave -> master)
//  Revision : 1.0  initial parametrised release
// ============================================================================
interface booth_mul_seq_if #(
    parameter int WIDTH = 16
) ();
    logic                 start;
    logic                 sign_mode;
    logic [WIDTH-1:0]     x;
    logic [WIDTH-1:0]     y;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   z;

    modport master (
        output start, sign_mode, x, y,
        input  busy, done, z
    );

    modport slave (
        input  start, sign_mode, x, y,
        output busy, done, z
    );
endinterface
`default_nettype wire

// File: rtl/booth_mul_seq_recode.sv
`default_nettype none
// ============================================================================
//  Module   : booth_recode
//  Purpose  : Combinational Booth recoder. Maps the low multiplier bits to a
//             digit in {0, +1, +2, -1, -2} times the multiplicand.
//  Ports    : bits_i   {q1, q0, q-1}; radix-2 uses only {q0, q-1}
//             radix4_i 1 = modified Booth table, 0 = radix-2 table
//             digit_o  selected digit
//             neg_o    digit is negative
//             dbl_o    digit has magnitude two (shift multiplicand by one)
//  Revision : 1.0  initial parametrised release
// ============================================================================
module booth_recode
    import booth_pkg::*;
(
    input  logic [2:0] bits_i,
    input  logic       radix4_i,
    output digit_t     digit_o,
    output logic       neg_o,
    output logic       dbl_o
);

    always_comb begin
        digit_o = ZERO;
        if (radix4_i) begin
            case (bits_i)
                3'b001, 3'b010: digit_o = P1;
                3'b011:         digit_o = P2;
                3'b100:         digit_o = M2;
                3'b101, 3'b110: digit_o = M1;
                default:        digit_o = ZERO;
            endcase
        end else begin
            case (bits_i[1:0])
                2'b01:   digit_o = P1;
                2'b10:   digit_o = M1;
                default: digit_o = ZERO;
            endcase
        end
    end

    assign neg_o = (digit_o == M1) || (digit_o == M2);
    assign dbl_o = (digit_o == P2) || (digit_o == M2);

endmodule
`default_nettype wire

// File: rtl/booth_mul_seq.sv
`default_nettype none
// ============================================================================
//  Module   : booth_mul_seq
//  Purpose  : Parametrised sequential Booth multiplier (radix-2 or radix-4),
//             signed/unsigned per operation, exact 2*WIDTH product.
//  Ports    : clk    rising-edge clock
//             rst_n  asynchronous active-low reset
//             bus    booth_mul_seq_if slave: start/sign_mode/x/y in,
//                    busy/done/z out
//  Revision : 1.0  initial parametrised release
// ============================================================================
module booth_mul_seq
    import booth_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int RADIX4 = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    booth_mul_seq_if.slave  bus
);

    localparam int EW    = WIDTH + 2;                  // extended operand width
    localparam int AW    = WIDTH + 3;                  // accumulator holds +/-2M
    localparam int N     = booth_iters(WIDTH, RADIX4 != 0);
    localparam int CW    = $clog2(N + 1);
    localparam int SHIFT = (RADIX4 != 0) ? 2 : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t             state_q;
    logic               busy_q;
    logic               done_q;
    logic [2*WIDTH-1:0] z_q;
    logic [AW-1:0]      m_q, m_neg_q;
    logic [AW-1:0]      a_q, a_d;
    logic [EW-1:0]      q_q, q_d;
    logic               qm1_q, qm1_d;
    logic [CW-1:0]      cnt_q;

    // Zero-extension keeps unsigned operands non-negative, so one signed
    // datapath serves both modes.
    logic [EW-1:0] x_ext, y_ext;
    logic [AW-1:0] m_load;
    assign x_ext  = bus.sign_mode ? {{2{bus.x[WIDTH-1]}}, bus.x} : {2'b00, bus.x};
    assign y_ext  = bus.sign_mode ? {{2{bus.y[WIDTH-1]}}, bus.y} : {2'b00, bus.y};
    assign m_load = {x_ext[EW-1], x_ext};

    digit_t digit;
    logic   neg, dbl;

    booth_recode u_recode (
        .bits_i   ({q_q[1:0], qm1_q}),
        .radix4_i (RADIX4 != 0),
        .digit_o  (digit),
        .neg_o    (neg),
        .dbl_o    (dbl)
    );

    logic [AW-1:0]        addend;
    logic [AW-1:0]        sum;
    logic signed [AW+EW:0] cat, cat_sh;

    // One iteration: add the selected multiple, then arithmetic-shift the
    // whole {A, Q, q-1} chain right by the radix step.
    always_comb begin
        addend = '0;
        if (digit != ZERO) begin
            if (neg) addend = dbl ? (m_neg_q << 1) : m_neg_q;
            else     addend = dbl ? (m_q << 1)     : m_q;
        end
        sum    = a_q + addend;
        cat    = {sum, q_q, qm1_q};
        cat_sh = cat >>> SHIFT;
        a_d    = cat_sh[AW+EW:EW+1];
        q_d    = cat_sh[EW:1];
        qm1_d  = cat_sh[0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            z_q     <= '0;
            m_q     <= '0;
            m_neg_q <= '0;
            a_q     <= '0;
            q_q     <= '0;
            qm1_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                // DONE accepts a new request exactly like IDLE, so
                // back-to-back operations have no bubble.
                IDLE, DONE: begin
                    if (bus.start) begin
                        m_q     <= m_load;
                        m_neg_q <= -m_load;
                        a_q     <= '0;
                        q_q     <= y_ext;
                        qm1_q   <= 1'b0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    a_q   <= a_d;
                    q_q   <= q_d;
                    qm1_q <= qm1_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        // Q holds the low EW product bits, A the rest.
                        z_q     <= {a_d[2*WIDTH-EW-1:0], q_d};
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.z    = z_q;

endmodule
`default_nettype wire
